// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Responder end of the CPU data-SRAM interface. Takes byte-enabled word
//   requests from the EX stage, stores them in a word array, and returns
//   registered read data for the MEM stage to byte-select. The read latency
//   can be configured. While a slow read is outstanding, the block asks the
//   pipeline to stall.
//
// Handshake: a request is offered when data_sram_en=1. It is accepted only
//   when the FSM is IDLE. While stallreq_for_mem is high, or during the LAST
//   cycle, the pipeline keeps presenting the same request. Those held inputs
//   are ignored. data_sram_rdata is valid READ_LAT cycles after acceptance.
//   It then holds its value until the next read completes.
//
// Parameters
//   ADDR_W    word-index bits; depth = 2**ADDR_W words of 32 bits
//   READ_LAT  read latency in cycles, 1..8
// Ports
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   data_sram_en      request valid
//   data_sram_wen     byte write enables (all zero = read)
//   data_sram_addr    byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata   write data, lane i = wdata[8i+7:8i]
//   data_sram_rdata   registered read data
//   stallreq_for_mem  pipeline stall request while a slow read is in flight
//   dbg_state         current FSM state (0 IDLE, 1 WAIT, 2 LAST)
// -----------------------------------------------------------------------------
module data_sram_resp #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  // WAIT lasts READ_LAT-2 cycles, so the counter starts at READ_LAT-3.
  localparam logic [2:0] CNT_INIT = 3'((READ_LAT >= 3) ? READ_LAT - 3 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] lat_idx_q;
  logic [ADDR_W-1:0] rd_idx;
  logic              accept, acc_wr, acc_rd;
  logic              stall;
  logic [31:0]       mem [DEPTH];
  logic              unused_addr_bits;

  // Byte offset and bits above the index are don't-care (address wraps).
  assign req_idx          = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign accept = ~rst & (state_q == S_IDLE) & data_sram_en;
  assign acc_wr = accept & (|data_sram_wen);
  assign acc_rd = accept & ~(|data_sram_wen);

  // There is a single array port. In LAST it serves the latched index;
  // otherwise it serves the incoming request.
  assign rd_idx = (state_q == S_LAST) ? lat_idx_q : req_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_rd && (READ_LAT >= 2)) begin
          stall   = 1'b1;
          state_d = (READ_LAT == 2) ? S_LAST : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt_q == 3'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_LAST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Reset aborts any read in flight, so the stall must drop immediately.
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 3'd0;
      lat_idx_q       <= '0;
      data_sram_rdata <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc_rd) lat_idx_q <= req_idx;
      if ((acc_rd && (READ_LAT == 1)) || (state_q == S_LAST))
        data_sram_rdata <= mem[rd_idx];
    end
  end

  // The array is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[req_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign stallreq_for_mem = stall;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//   Drives one request stream into two instances (READ_LAT=1 and READ_LAT=3).
//   A word-array model per instance predicts rdata and stall every cycle.
//   Directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata3;
  logic        stall1, stall3;
  logic [1:0]  dbg1, dbg3;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata1), .stallreq_for_mem(stall1), .dbg_state(dbg1)
  );

  data_sram_resp #(.ADDR_W(10), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata3), .stallreq_for_mem(stall3), .dbg_state(dbg3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models READ_LAT=1, index 1 models READ_LAT=3.
  // A read accepted in cycle T has its result visible from cycle T+L.
  // New requests are ignored while the current cycle is before T+L.
  // Stall is high from T through T+L-2.
  logic [31:0] m_mem [2][1024];
  logic [31:0] m_rdata [2];
  logic [31:0] m_pend [2];
  int          m_done [2];
  int          cyc = 0;
  bit          started = 1'b0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit exp_stall(input int d);
    if (rst) return 1'b0;
    if (cyc < m_done[d]) return (cyc <= m_done[d] - 2);
    return en && (wen == 4'd0) && (lat_of(d) >= 2);
  endfunction

  always @(posedge clk) begin
    int idx;
    idx = int'(addr / 32'd4 % 32'd1024);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_rdata[d] = 32'd0;
        m_done[d]  = 0;
      end else if (cyc < m_done[d]) begin
        if (cyc == m_done[d] - 1) m_rdata[d] = m_pend[d];
      end else if (en) begin
        if (wen != 4'd0) begin
          for (int i = 0; i < 4; i++)
            if (wen[i]) m_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
        end else if (lat_of(d) == 1) begin
          m_rdata[d] = m_mem[d][idx];
        end else begin
          m_pend[d] = m_mem[d][idx];
          m_done[d] = cyc + lat_of(d);
        end
      end
    end
    cyc++;
    started = 1'b1;
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("rdata_lat1", rdata1, m_rdata[0]);
      chk("rdata_lat3", rdata3, m_rdata[1]);
      chk("stall_lat1", {31'd0, stall1}, {31'd0, exp_stall(0)});
      chk("stall_lat3", {31'd0, stall3}, {31'd0, exp_stall(1)});
    end
  end

  // ---------------- driver ----------------
  // Applies inputs for one cycle, then returns mid-cycle so the caller
  // can sample that cycle's outputs.
  task automatic step(input logic r, input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; en = e; wen = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_rdata3", rdata3, 32'd0);
    chk("reset_state3", {30'd0, dbg3}, 32'd0);

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 4'hF, i * 4, $urandom);

    // Byte-lane merge.
    step(1'b0, 1'b1, 4'hF,    32'h40, 32'h11223344);
    step(1'b0, 1'b1, 4'b0100, 32'h40, 32'h00AB0000);
    step(1'b0, 1'b1, 4'd0,    32'h40, 32'd0);
    chk("merge_stall3_T", {31'd0, stall3}, 32'd1);
    idle(1);
    chk("merge_lat1", rdata1, 32'h11AB3344);
    idle(2);
    chk("merge_lat3", rdata3, 32'h11AB3344);

    // Back-to-back reads at latency 1.
    step(1'b0, 1'b1, 4'hF, 32'h44, 32'hA5A50044);
    step(1'b0, 1'b1, 4'hF, 32'h48, 32'h5A5A0048);
    step(1'b0, 1'b1, 4'd0, 32'h40, 32'd0);
    chk("b2b_stall1_T", {31'd0, stall1}, 32'd0);
    step(1'b0, 1'b1, 4'd0, 32'h44, 32'd0);
    chk("b2b_lat1_T1", rdata1, 32'h11AB3344);
    step(1'b0, 1'b1, 4'd0, 32'h48, 32'd0);
    chk("b2b_lat1_T2", rdata1, 32'hA5A50044);
    idle(1);
    chk("b2b_lat1_T3", rdata1, 32'h5A5A0048);
    chk("b2b_lat3_first", rdata3, 32'h11AB3344);

    // Latency 3 with the request held while stalled.
    idle(2);
    step(1'b0, 1'b1, 4'd0, 32'h48, 32'd0);
    chk("lat3_stall_T", {31'd0, stall3}, 32'd1);
    step(1'b0, 1'b1, 4'd0, 32'h48, 32'd0);
    chk("lat3_stall_T1", {31'd0, stall3}, 32'd1);
    chk("lat3_hold_T1", rdata3, 32'h11AB3344);
    step(1'b0, 1'b1, 4'd0, 32'h48, 32'd0);
    chk("lat3_stall_T2", {31'd0, stall3}, 32'd0);
    idle(1);
    chk("lat3_data_T3", rdata3, 32'h5A5A0048);
    chk("lat3_stall_T3", {31'd0, stall3}, 32'd0);

    // Reset in the middle of a latency-3 read.
    step(1'b0, 1'b1, 4'd0, 32'h40, 32'd0);
    step(1'b0, 1'b1, 4'd0, 32'h40, 32'd0);
    step(1'b1, 1'b1, 4'd0, 32'h40, 32'd0);
    step(1'b1, 1'b1, 4'd0, 32'h40, 32'd0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("rst_mid_rdata3", rdata3, 32'd0);
    chk("rst_mid_stall3", {31'd0, stall3}, 32'd0);
    chk("rst_mid_state3", {30'd0, dbg3}, 32'd0);
    idle(3);
    chk("rst_mid_aborted3", rdata3, 32'd0);

    // Address wrap and byte-offset alignment.
    step(1'b0, 1'b1, 4'hF, 32'h1002, 32'hDEADBEEF);
    step(1'b0, 1'b1, 4'd0, 32'h0000, 32'd0);
    idle(3);
    chk("wrap_lat1", rdata1, 32'hDEADBEEF);
    chk("wrap_lat3", rdata3, 32'hDEADBEEF);

    // Hold across idle cycles and an unrelated write.
    step(1'b0, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
    step(1'b0, 1'b1, 4'd0, 32'h80, 32'd0);
    idle(5);
    step(1'b0, 1'b1, 4'hF, 32'h200, $urandom);
    idle(1);
    chk("hold_lat1", rdata1, 32'hCAFEF00D);
    chk("hold_lat3", rdata3, 32'hCAFEF00D);

    // Randomised traffic on a small set of words, random upper and offset
    // address bits, and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), w, a, $urandom);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
